pong_arena_wall: RTL and testbench

Parametrised arena-border renderer for the Pong VGA pipeline. For each pixel coordinate it decides whether the pixel belongs to an enabled border side and outputs the border colour. Per-side "hit flash" counters let the ball logic light a struck wall in a flash colour for a programmable number of frames. Outputs are registered, and the block feeds the pixel mux alongside the paddle and ball renderers.

---
 rtl/pong_arena_wall.sv | 98 +++++++++
 tb/tb_pong_arena_wall.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pong_arena_wall.sv
// pong_arena_wall: arena border renderer for the Pong VGA pipeline.
// Decides per pixel whether it lies on an enabled border side and emits the
// border colour one cycle later. Optional per-side hit flash counters are
// built only when the WALL_FLASH_EN macro is defined.
module pong_arena_wall #(
   parameter int          H_RES        = 640,
   parameter int          V_RES        = 480,
   parameter int          THICKNESS    = 10,
   parameter logic [3:0]  SIDES        = 4'b0111,
   parameter logic [11:0] WALL_COLOR   = 12'hFFF,
   parameter logic [11:0] FLASH_COLOR  = 12'hF00,
   parameter int          FLASH_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        frame_tick,
   input  logic [3:0]  hit,
   output logic        wall_on,
   output logic [11:0] wall_rgb,
   output logic [3:0]  flash_active
);

   // Thresholds pre-sized to the coordinate width so the compares stay 10-bit.
   localparam logic [9:0] L_THK   = 10'(THICKNESS);
   localparam logic [9:0] L_RIGHT = 10'(H_RES - THICKNESS);
   localparam logic [9:0] L_BOT   = 10'(V_RES - THICKNESS);

   logic [3:0]  w_cover;
   logic        w_on;
   logic [3:0]  w_flash;
   logic [11:0] w_rgb;
   logic        r_wall_on;
   logic [11:0] r_wall_rgb;

   // Side coverage; bit order matches SIDES (left, top, bottom, right).
   // Out-of-range coordinates go through the same compares on purpose.
   assign w_cover = {pixel_x >= L_RIGHT, pixel_y >= L_BOT,
                     pixel_y <  L_THK,   pixel_x <  L_THK}
                    & SIDES & {4{video_on}};
   assign w_on    = |w_cover;

`ifdef WALL_FLASH_EN
   localparam int CW = $clog2(FLASH_FRAMES + 1);

   logic [3:0][CW-1:0] r_cnt;

   for (genvar i = 0; i < 4; i++) begin : g_side
      // Flash counter: a hit (re)loads and wins over a same-cycle frame tick;
      // otherwise each frame tick counts down, saturating at zero.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)
            r_cnt[i] <= '0;
         else if (hit[i] && SIDES[i])
            r_cnt[i] <= CW'(FLASH_FRAMES);
         else if (frame_tick && (r_cnt[i] != '0))
            r_cnt[i] <= r_cnt[i] - CW'(1);
      end
      assign w_flash[i] = (r_cnt[i] != '0);
   end

   assign flash_active = w_flash;
`else
   logic w_unused;

   // Without the flash feature the hit/frame inputs have no effect.
   assign w_unused     = ^{hit, frame_tick, 8'(FLASH_FRAMES)};
   assign w_flash      = 4'b0000;
   assign flash_active = 4'b0000;
`endif

   // Colour select: a flash on any covering side owns the whole pixel,
   // which is what makes a corner light up when either wall is struck.
   always_comb begin
      w_rgb = 12'h000;
      if (|(w_cover & w_flash))
         w_rgb = FLASH_COLOR;
      else if (w_on)
         w_rgb = WALL_COLOR;
   end

   // Output register: one-cycle latency to line up with delayed syncs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wall_on  <= 1'b0;
         r_wall_rgb <= 12'h000;
      end else begin
         r_wall_on  <= w_on;
         r_wall_rgb <= w_rgb;
      end
   end

   assign wall_on  = r_wall_on;
   assign wall_rgb = r_wall_rgb;

endmodule

// File: tb/tb_pong_arena_wall.sv
// Directed bench for pong_arena_wall at default parameters. Flash checks
// adapt to whether WALL_FLASH_EN is defined for the build.
module tb_pong_arena_wall;

   logic        clk = 1'b0;
   logic        rstn;
   logic [9:0]  pixel_x;
   logic [9:0]  pixel_y;
   logic        video_on;
   logic        frame_tick;
   logic [3:0]  hit;
   logic        wall_on;
   logic [11:0] wall_rgb;
   logic [3:0]  flash_active;

   int n_cmp = 0;
   int n_bad = 0;

   pong_arena_wall dut (
      .clk          (clk),
      .rstn         (rstn),
      .pixel_x      (pixel_x),
      .pixel_y      (pixel_y),
      .video_on     (video_on),
      .frame_tick   (frame_tick),
      .hit          (hit),
      .wall_on      (wall_on),
      .wall_rgb     (wall_rgb),
      .flash_active (flash_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
   endtask

   task automatic pix(input int x, input int y, input logic v);
      pixel_x  = 10'(x);
      pixel_y  = 10'(y);
      video_on = v;
      tick();
   endtask

   initial begin
      rstn = 1'b1; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
      frame_tick = 1'b0; hit = 4'b0000;
      #1 rstn = 1'b0;
      #1;
      chk("rst_on",    32'(wall_on),      0);
      chk("rst_rgb",   32'(wall_rgb),     0);
      chk("rst_flash", 32'(flash_active), 0);
      tick();
      rstn = 1'b1;

      // Basic coverage scan
      pix(5, 200, 1'b1);   chk("left_on",  32'(wall_on), 1); chk("left_rgb",  32'(wall_rgb), 'hFFF);
      pix(300, 5, 1'b1);   chk("top_on",   32'(wall_on), 1); chk("top_rgb",   32'(wall_rgb), 'hFFF);
      pix(300, 475, 1'b1); chk("bot_on",   32'(wall_on), 1); chk("bot_rgb",   32'(wall_rgb), 'hFFF);
      pix(635, 200, 1'b1); chk("right_on", 32'(wall_on), 0); chk("right_rgb", 32'(wall_rgb), 'h000);
      pix(0, 0, 1'b0);     chk("blank_on", 32'(wall_on), 0); chk("blank_rgb", 32'(wall_rgb), 'h000);

      // Thickness boundaries and out-of-range coordinates
      pix(9, 200, 1'b1);   chk("x9_on",    32'(wall_on), 1);
      pix(10, 200, 1'b1);  chk("x10_on",   32'(wall_on), 0);
      pix(300, 9, 1'b1);   chk("y9_on",    32'(wall_on), 1);
      pix(300, 10, 1'b1);  chk("y10_on",   32'(wall_on), 0);
      pix(300, 470, 1'b1); chk("y470_on",  32'(wall_on), 1);
      pix(300, 469, 1'b1); chk("y469_on",  32'(wall_on), 0);
      pix(700, 5, 1'b1);   chk("oor_on",   32'(wall_on), 1);
      pix(700, 200, 1'b1); chk("oor2_on",  32'(wall_on), 0);

      // Disabled right side ignores hits in every build
      hit = 4'b1000; tick(); hit = 4'b0000;
      chk("hit3_flash", 32'(flash_active), 0);
      tick();
      chk("hit3_flash2", 32'(flash_active), 0);

`ifdef WALL_FLASH_EN
      // Left flash: active next cycle, colour one cycle after that
      pix(3, 100, 1'b1);
      hit = 4'b0001; tick(); hit = 4'b0000;
      chk("lf_act",  32'(flash_active), 'b0001);
      chk("lf_rgb0", 32'(wall_rgb), 'hFFF);
      tick();
      chk("lf_rgb1", 32'(wall_rgb), 'hF00);
      for (int k = 1; k <= 8; k++) begin
         frame();
         chk($sformatf("lf_rgb_t%0d", k), 32'(wall_rgb), 'hF00);
         chk($sformatf("lf_act_t%0d", k), 32'(flash_active[0]), (k < 8) ? 1 : 0);
      end
      tick();
      chk("lf_rgb_end", 32'(wall_rgb), 'hFFF);

      // Top flash, reload coincident with a frame tick at count 3; corner (2,2)
      pix(2, 2, 1'b1);
      hit = 4'b0010; tick(); hit = 4'b0000;
      chk("tf_act", 32'(flash_active), 'b0010);
      for (int k = 0; k < 5; k++) frame();
      chk("tf_corner", 32'(wall_rgb), 'hF00);
      hit = 4'b0010; frame_tick = 1'b1; tick();
      hit = 4'b0000; frame_tick = 1'b0;
      for (int k = 0; k < 7; k++) frame();
      chk("tf_reload7", 32'(flash_active[1]), 1);
      chk("tf_corner2", 32'(wall_rgb), 'hF00);
      frame();
      chk("tf_reload8", 32'(flash_active[1]), 0);
      tick();
      chk("tf_corner_end", 32'(wall_rgb), 'hFFF);

      // Asynchronous reset during a left flash
      pix(3, 100, 1'b1);
      hit = 4'b0001; tick(); hit = 4'b0000;
      tick();
      chk("ar_pre", 32'(wall_rgb), 'hF00);
      #2 rstn = 1'b0;
      #1;
      chk("ar_on",    32'(wall_on),      0);
      chk("ar_rgb",   32'(wall_rgb),     0);
      chk("ar_flash", 32'(flash_active), 0);
      tick();
      rstn = 1'b1;
      tick();
      chk("ar_post_on",  32'(wall_on),      1);
      chk("ar_post_rgb", 32'(wall_rgb),     'hFFF);
      chk("ar_post_fl",  32'(flash_active), 0);
`else
      // Flash feature absent: hits and frame ticks change nothing
      pix(3, 100, 1'b1);
      hit = 4'b1111; tick(); hit = 4'b0000;
      chk("nf_act", 32'(flash_active), 0);
      tick();
      chk("nf_rgb", 32'(wall_rgb), 'hFFF);
      frame();
      chk("nf_rgb2", 32'(wall_rgb), 'hFFF);
      pix(2, 2, 1'b1);
      hit = 4'b1111; frame_tick = 1'b1; tick();
      hit = 4'b0000; frame_tick = 1'b0;
      tick();
      chk("nf_corner", 32'(wall_rgb), 'hFFF);
      chk("nf_act2",   32'(flash_active), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
